// File: rtl/fp_pkg.sv
// Shared floating-point types and constants.
// Used by the MUL unit and its round/normalize helper.
package fp_pkg;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_OVERFLOW  = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_INVALID   = 3'd3
  } o_err_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int EXP_BIAS = 127;
  localparam int EXP_BITS = 8;
  localparam int SIG_BITS = 23;

  typedef enum logic [2:0] {
    ST_GET,
    ST_UNPACK,
    ST_SPECIAL,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_PUT
  } state_t;

  typedef struct packed {
    logic                s;
    logic [EXP_BITS-1:0] e;
    logic [SIG_BITS:0]   m;
    logic                emax;
  } fp_unp_t;

  // Subnormals get the minimum exponent and no hidden bit.
  function automatic fp_unp_t unpack(input logic [31:0] x);
    fp_unp_t u;
    logic    nz;
    nz     = |x[30:23];
    u.s    = x[31];
    u.e    = nz ? x[30:23] : 8'd1;
    u.m    = {nz, x[22:0]};
    u.emax = &x[30:23];
    return u;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Leading-zero normalize, denormalize and
// round-to-nearest-even for a 48-bit significand.
module fp_round_norm
  import fp_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [10:0] exp_i,
  input  logic [47:0]        mant_i,
  output logic [31:0]        res_o,
  output logic               ovf_o,
  output logic               unf_o
);

  logic [5:0]         lz;
  logic [47:0]        norm;
  logic signed [10:0] e1;
  logic signed [10:0] ef;
  logic [10:0]        sh;
  logic [5:0]         shc;
  logic [95:0]        ext;
  logic [23:0]        sig;
  logic [23:0]        sig_r;
  logic               g;
  logic               r;
  logic               s;
  logic               up;
  logic               inexact;
  logic [24:0]        sum;

  // mant_i has weight 2^(exp_i-bias) at bit 46
  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++)
      if (mant_i[i]) lz = 6'(47 - i);
    norm = mant_i << lz;
    e1 = exp_i + 11'sd1 - $signed(11'(lz));
    sh = 11'd0;
    ef = e1;
    if (e1 < 11'sd1) begin
      sh = 11'(11'sd1 - e1);
      ef = 11'sd1;
    end
    shc = (sh > 11'd50) ? 6'd50 : sh[5:0];
    ext = {norm, 48'd0} >> shc;
    sig = ext[95:72];
    g = ext[71];
    r = ext[70];
    s = |ext[69:0];
    inexact = g | r | s;
    up = g & (r | s | sig[0]);
    sum = {1'b0, sig} + 25'(up);
    sig_r = sum[23:0];
    if (sum[24]) begin
      sig_r = sum[24:1];
      ef = ef + 11'sd1;
    end
    ovf_o = ef > 11'sd254;
    unf_o = ~sig_r[SIG_BITS] & inexact;
    if (ovf_o)
      res_o = {sign_i, 8'hFF, 23'd0};
    else
      res_o = {sign_i,
               sig_r[23] ? ef[7:0] : 8'd0,
               sig_r[22:0]};
  end

endmodule

// File: rtl/fp32_multiplier.sv
// IEEE-754 single-precision MUL unit with
// strobe/ack handshakes and fixed latency.
module fp32_multiplier
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_A,
  input  logic        strb_A,
  output logic        in_A_ack,
  input  logic [31:0] in_B,
  input  logic        strb_B,
  output logic        in_B_ack,
  output logic [31:0] output_prod,
  output logic        output_prod_stb,
  input  logic        out_prod_ack,
  output o_err_t      err_o
);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               a_held_q, a_held_d;
  logic               b_held_q, b_held_d;
  logic               a_ack_q, a_ack_d;
  logic               b_ack_q, b_ack_d;
  fp_unp_t            ua_q, ua_d, ub_q, ub_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  o_err_t             spec_err_q, spec_err_d;
  logic               sign_q, sign_d;
  logic signed [10:0] exp_q, exp_d;
  logic [47:0]        prod_q, prod_d;
  logic [31:0]        rn_res_q, rn_res_d;
  o_err_t             rn_err_q, rn_err_d;
  logic [31:0]        out_q, out_d;
  o_err_t             err_q, err_d;
  logic               stb_q, stb_d;

  logic [31:0]        rn_res;
  logic               rn_ovf;
  logic               rn_unf;
  logic               nan_a, nan_b;
  logic               inf_a, inf_b;
  logic               zero_a, zero_b;
  logic               sgn;

  fp_round_norm u_rn (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .mant_i (prod_q),
    .res_o  (rn_res),
    .ovf_o  (rn_ovf),
    .unf_o  (rn_unf)
  );

  // operand classes for the special-case stage
  always_comb begin
    nan_a  = ua_q.emax & |ua_q.m[22:0];
    nan_b  = ub_q.emax & |ub_q.m[22:0];
    inf_a  = ua_q.emax & ~|ua_q.m[22:0];
    inf_b  = ub_q.emax & ~|ub_q.m[22:0];
    zero_a = ~|ua_q.m;
    zero_b = ~|ub_q.m;
    sgn    = ua_q.s ^ ub_q.s;
  end

  // FSM next state and datapath stage updates
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_held_d   = a_held_q;
    b_held_d   = b_held_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    ua_d       = ua_q;
    ub_d       = ub_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_err_d = spec_err_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    prod_d     = prod_q;
    rn_res_d   = rn_res_q;
    rn_err_d   = rn_err_q;
    out_d      = out_q;
    err_d      = err_q;
    stb_d      = stb_q;
    unique case (state_q)
      ST_GET: begin
        if (strb_A && !a_held_q) begin
          a_d      = in_A;
          a_held_d = 1'b1;
          a_ack_d  = 1'b1;
        end
        if (strb_B && !b_held_q) begin
          b_d      = in_B;
          b_held_d = 1'b1;
          b_ack_d  = 1'b1;
        end
        if (a_held_q && b_held_q)
          state_d = ST_UNPACK;
      end
      ST_UNPACK: begin
        ua_d    = unpack(a_q);
        ub_d    = unpack(b_q);
        state_d = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        spec_d     = 1'b1;
        spec_err_d = ERR_NONE;
        spec_res_d = {sgn, 31'd0};
        if (nan_a || nan_b ||
            (inf_a && zero_b) ||
            (zero_a && inf_b)) begin
          spec_res_d = QNAN;
          spec_err_d = ERR_INVALID;
        end else if (inf_a || inf_b)
          spec_res_d = {sgn, 8'hFF, 23'd0};
        else if (!(zero_a || zero_b))
          spec_d = 1'b0;
        state_d = ST_MULT;
      end
      ST_MULT: begin
        prod_d  = 48'(ua_q.m) * 48'(ub_q.m);
        exp_d   = $signed({3'd0, ua_q.e})
                + $signed({3'd0, ub_q.e})
                - $signed(11'(EXP_BIAS));
        sign_d  = sgn;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        rn_res_d = rn_res;
        rn_err_d = rn_ovf ? ERR_OVERFLOW :
                   rn_unf ? ERR_UNDERFLOW :
                            ERR_NONE;
        state_d  = ST_ROUND;
      end
      ST_ROUND: begin
        out_d   = spec_q ? spec_res_q : rn_res_q;
        err_d   = spec_q ? spec_err_q : rn_err_q;
        stb_d   = 1'b1;
        state_d = ST_PUT;
      end
      ST_PUT: begin
        if (out_prod_ack) begin
          stb_d    = 1'b0;
          a_held_d = 1'b0;
          b_held_d = 1'b0;
          state_d  = ST_GET;
        end
      end
      default: state_d = ST_GET;
    endcase
  end

  // state and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_GET;
      a_q        <= '0;
      b_q        <= '0;
      a_held_q   <= 1'b0;
      b_held_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      ua_q       <= '0;
      ub_q       <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_err_q <= ERR_NONE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      prod_q     <= '0;
      rn_res_q   <= '0;
      rn_err_q   <= ERR_NONE;
      out_q      <= '0;
      err_q      <= ERR_NONE;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_held_q   <= a_held_d;
      b_held_q   <= b_held_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      ua_q       <= ua_d;
      ub_q       <= ub_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_err_q <= spec_err_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      prod_q     <= prod_d;
      rn_res_q   <= rn_res_d;
      rn_err_q   <= rn_err_d;
      out_q      <= out_d;
      err_q      <= err_d;
      stb_q      <= stb_d;
    end
  end

  assign in_A_ack        = a_ack_q;
  assign in_B_ack        = b_ack_q;
  assign output_prod     = out_q;
  assign output_prod_stb = stb_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Random and directed bench for fp32_multiplier,
// checked against a real-arithmetic reference.
module tb_fp32_multiplier;
  import fp_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_A;
  logic        strb_A;
  logic        in_A_ack;
  logic [31:0] in_B;
  logic        strb_B;
  logic        in_B_ack;
  logic [31:0] output_prod;
  logic        output_prod_stb;
  logic        out_prod_ack;
  o_err_t      err_o;

  int n_checks = 0;
  int n_errors = 0;

  fp32_multiplier dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_A            (in_A),
    .strb_A          (strb_A),
    .in_A_ack        (in_A_ack),
    .in_B            (in_B),
    .strb_B          (strb_B),
    .in_B_ack        (in_B_ack),
    .output_prod     (output_prod),
    .output_prod_stb (output_prod_stb),
    .out_prod_ack    (out_prod_ack),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic real pow2(input int p);
    logic [63:0] bits;
    bits = {1'b0, 11'(1023 + p), 52'd0};
    return $bitstoreal(bits);
  endfunction

  // magnitude of a finite single as a real
  function automatic real mag(input logic [31:0] x);
    real m;
    int  ex;
    ex = int'(x[30:23]);
    m  = real'(x[22:0]);
    if (ex != 0) m = m + 8388608.0;
    else ex = 1;
    return m * pow2(ex - 150);
  endfunction

  task automatic model(input  logic [31:0] a,
                       input  logic [31:0] b,
                       output logic [31:0] r,
                       output logic [2:0]  e);
    bit          nan_a, nan_b, inf_a, inf_b;
    bit          zro_a, zro_b, s, inexact;
    real         v, x, fr;
    logic [63:0] vb;
    int          k, q, n, ef;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    zro_a = a[30:0] == 0;
    zro_b = b[30:0] == 0;
    s = a[31] ^ b[31];
    e = 3'd0;
    if (nan_a || nan_b || (inf_a && zro_b) ||
        (zro_a && inf_b)) begin
      r = 32'h7FC00000;
      e = 3'd3;
    end else if (inf_a || inf_b) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zro_a || zro_b) begin
      r = {s, 31'd0};
    end else begin
      v  = mag(a) * mag(b);
      vb = $realtobits(v);
      k  = int'(vb[62:52]) - 1023;
      if (k < -126) k = -126;
      q  = k - 23;
      x  = v * pow2(-q);
      n  = $rtoi(x);
      fr = x - real'(n);
      inexact = fr != 0.0;
      if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
      if (n >= (1 << 24)) begin
        n = n / 2;
        k++;
      end
      if (n >= (1 << 23)) begin
        ef = k + 127;
        if (ef > 254) begin
          r = {s, 8'hFF, 23'd0};
          e = 3'd1;
        end else
          r = {s, 8'(ef), n[22:0]};
      end else begin
        r = {s, 8'd0, n[22:0]};
        if (inexact) e = 3'd2;
      end
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x[30:23] = 8'd0;
      1: x[30:23] = 8'hFF;
      2: x[30:0]  = 31'd0;
      3: x[30:23] = 8'($urandom_range(1, 40));
      4: x[30:23] = 8'($urandom_range(200, 254));
      5: x[30:23] = 8'($urandom_range(80, 140));
      default: ;
    endcase
    return x;
  endfunction

  task automatic do_mul(input logic [31:0] a,
                        input logic [31:0] b,
                        input int da,
                        input int db,
                        input int hold,
                        input int ack_wait);
    logic [31:0] er;
    logic [2:0]  ee;
    int t, ta, tb, na, nb, tn;
    bit ad, bd;
    string id;
    model(a, b, er, ee);
    id = $sformatf("%h*%h", a, b);
    t = 0; ta = 0; tb = 0; na = 0; nb = 0;
    ad = 0; bd = 0;
    while (!output_prod_stb && t < 40) begin
      strb_A = (t >= da) && (!ad || t < ta + hold);
      strb_B = (t >= db) && (!bd || t < tb + hold);
      in_A = ad ? ~a : a;
      in_B = bd ? ~b : b;
      @(posedge clk); #1;
      t++;
      if (in_A_ack) begin
        na++;
        if (!ad) begin ad = 1; ta = t; end
      end
      if (in_B_ack) begin
        nb++;
        if (!bd) begin bd = 1; tb = t; end
      end
    end
    strb_A = 0;
    strb_B = 0;
    tn = (ta > tb) ? ta : tb;
    chk({"stb ", id}, 32'(output_prod_stb), 32'd1);
    chk({"latency ", id}, 32'(t - tn), 32'd6);
    chk({"prod ", id}, output_prod, er);
    chk({"err ", id}, 32'(err_o), 32'(ee));
    chk({"ackA ", id}, 32'(na), 32'd1);
    chk({"ackB ", id}, 32'(nb), 32'd1);
    for (int i = 0; i < ack_wait; i++) begin
      strb_A = 1; strb_B = 1;
      in_A = $urandom; in_B = $urandom;
      @(posedge clk); #1;
      chk("hold_ack", 32'({in_A_ack, in_B_ack}), 32'd0);
      chk("hold_prod", output_prod, er);
      chk("hold_err", 32'(err_o), 32'(ee));
      chk("hold_stb", 32'(output_prod_stb), 32'd1);
    end
    strb_A = 0;
    strb_B = 0;
    out_prod_ack = 1;
    @(posedge clk); #1;
    out_prod_ack = 0;
    chk({"release ", id}, 32'(output_prod_stb), 32'd0);
  endtask

  initial begin
    int seen;
    reset_n = 0; strb_A = 0; strb_B = 0;
    in_A = 0; in_B = 0; out_prod_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prod", output_prod, 32'd0);
    chk("rst_stb", 32'(output_prod_stb), 32'd0);
    chk("rst_ack", 32'({in_A_ack, in_B_ack}), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    reset_n = 1;

    do_mul(32'h40000000, 32'h40400000, 0, 0, 0, 0);
    do_mul(32'h3FC00000, 32'hC0000000, 0, 3, 0, 0);
    do_mul(32'h7F800000, 32'h00000000, 1, 0, 0, 0);
    do_mul(32'h7FC00001, 32'h3F800000, 0, 0, 0, 0);
    do_mul(32'h7F7FFFFF, 32'h40000000, 2, 1, 0, 0);
    do_mul(32'h00800000, 32'h3F000000, 0, 0, 0, 0);
    do_mul(32'h00800000, 32'h00800000, 0, 0, 0, 0);
    chk("dir_sub_err", 32'(err_o), 32'd2);
    do_mul(32'h40000000, 32'h40400000, 0, 2, 3, 10);

    // abort mid-MULT
    in_A = 32'h40000000; in_B = 32'h40400000;
    strb_A = 1; strb_B = 1;
    @(posedge clk); #1;
    strb_A = 0; strb_B = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_state", 32'(dut.state_q), 32'(ST_MULT));
    reset_n = 0;
    #1;
    chk("abort_prod", output_prod, 32'd0);
    chk("abort_stb", 32'(output_prod_stb), 32'd0);
    chk("abort_err", 32'(err_o), 32'd0);
    chk("abort_state", 32'(dut.state_q), 32'(ST_GET));
    #2;
    reset_n = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (output_prod_stb) seen++;
    end
    chk("abort_no_stb", 32'(seen), 32'd0);

    for (int i = 0; i < 80; i++)
      do_mul(rnd_op(), rnd_op(),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
